branch_resolver: RTL and testbench

- Consumer side of the ZVN flag register: reads the committed flags and resolves conditional branches (B, and BR when `br_reg`=1) for the pipelined core.
- Tracks in-flight flag-writing instructions and stalls the branch in ID until every older flag write has committed.
- Evaluates the 3-bit condition code, computes the target and issues a registered redirect to fetch.

---
 rtl/branch_resolver_pkg.sv | 25 ++
 rtl/branch_resolver_cond_eval.sv | 34 +++
 rtl/branch_resolver.sv | 184 ++++++++++++++++++
 tb/tb_branch_resolver.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolver_pkg.sv
// Shared definitions for the branch resolver.
//   - Condition-code encodings (CC_NE .. CC_UNCOND)
//   - Bit positions of Z/V/N inside the committed flag vector
//   - FSM state encoding for the resolver (IDLE / WAIT)
package branch_resolver_pkg;

  localparam logic [2:0] CC_NE     = 3'b000;
  localparam logic [2:0] CC_EQ     = 3'b001;
  localparam logic [2:0] CC_GT     = 3'b010;
  localparam logic [2:0] CC_LT     = 3'b011;
  localparam logic [2:0] CC_GTE    = 3'b100;
  localparam logic [2:0] CC_LTE    = 3'b101;
  localparam logic [2:0] CC_OVFL   = 3'b110;
  localparam logic [2:0] CC_UNCOND = 3'b111;

  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } br_state_e;

endpackage

// File: rtl/branch_resolver_cond_eval.sv
// Combinational condition-code evaluator.
// Ports:
//   ccc       in  [2:0]  condition code
//   flags     in  [2:0]  committed flags {Z, V, N}
//   cond_true out        branch condition satisfied
module branch_resolver_cond_eval
  import branch_resolver_pkg::*;
(
  input  logic [2:0] ccc,
  input  logic [2:0] flags,
  output logic       cond_true
);

  logic z, v, n;

  always_comb begin
    z = flags[FLAG_Z];
    v = flags[FLAG_V];
    n = flags[FLAG_N];
    cond_true = 1'b0;
    case (ccc)
      CC_NE:     cond_true = !z;
      CC_EQ:     cond_true = z;
      CC_GT:     cond_true = !z && !n;
      CC_LT:     cond_true = n;
      CC_GTE:    cond_true = z || (!z && !n);
      CC_LTE:    cond_true = n || z;
      CC_OVFL:   cond_true = v;
      CC_UNCOND: cond_true = 1'b1;
      default:   cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolver.sv
// Branch resolver: consumes the committed ZVN flags, stalls a branch in ID
// while older flag-writing instructions are still in flight, evaluates the
// condition and issues a registered redirect to fetch.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   flags[2:0]                  committed flags {Z, V, N}
//   fw_issue / fw_commit        flag-writer enters EX / flag register write
//   br_valid, br_ccc, br_reg,   branch request in ID (held while stall=1)
//   br_pc_plus2, br_imm,
//   br_rs_data
//   stall, br_ack               combinational handshake back to ID
//   redirect_valid/redirect_pc  registered redirect, one cycle after br_ack
//   taken                       registered result of last resolved branch
//   err                         sticky pending-counter over/underflow
//   stat_branches, stat_taken   saturating counters, only with BRANCH_STATS_EN
// Handshake: br_valid is the request; br_ack=1 in the cycle the branch is
// consumed; stall=1 tells ID to hold the request unchanged. br_valid may
// drop while stalled (flush), which discards the branch silently.
// Optional macro: BRANCH_STATS_EN adds the statistics counters.
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int MAX_INFLIGHT = 3,
  parameter int PC_W         = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      flags,
  input  logic            fw_issue,
  input  logic            fw_commit,
  input  logic            br_valid,
  input  logic [2:0]      br_ccc,
  input  logic            br_reg,
  input  logic [PC_W-1:0] br_pc_plus2,
  input  logic [8:0]      br_imm,
  input  logic [PC_W-1:0] br_rs_data,
  output logic            stall,
  output logic            br_ack,
  output logic            redirect_valid,
  output logic [PC_W-1:0] redirect_pc,
  output logic            taken,
  output logic            err
`ifdef BRANCH_STATS_EN
  ,
  output logic [15:0]     stat_branches,
  output logic [15:0]     stat_taken
`endif
);

  localparam int PEND_W = $clog2(MAX_INFLIGHT + 1);

  br_state_e         state_q, state_d;
  logic [PEND_W-1:0] pending_q, pending_d;
  logic              err_q, err_d;
  logic              redirect_valid_q, redirect_valid_d;
  logic [PC_W-1:0]   redirect_pc_q, redirect_pc_d;
  logic              taken_q, taken_d;

  logic              resolve;
  logic              cond_true;
  logic [PC_W-1:0]   imm_ext;
  logic [PC_W-1:0]   target;

  branch_resolver_cond_eval u_cond_eval (
    .ccc       (br_ccc),
    .flags     (flags),
    .cond_true (cond_true)
  );

  // A writer issuing this cycle is older than the branch, so it blocks
  // resolution even though it is not yet counted in pending_q.
  assign resolve = br_valid && (br_ccc == CC_UNCOND || (pending_q == '0 && !fw_issue));

  always_comb begin
    imm_ext = {{(PC_W-9){br_imm[8]}}, br_imm};
    target  = br_reg ? br_rs_data : (br_pc_plus2 + (imm_ext << 1));
  end

  // In-flight flag-writer counter; out-of-range updates hold and flag err.
  always_comb begin
    pending_d = pending_q;
    err_d     = err_q;
    if (fw_issue && !fw_commit) begin
      if (pending_q == PEND_W'(MAX_INFLIGHT)) err_d = 1'b1;
      else                                    pending_d = pending_q + 1'b1;
    end else if (fw_commit && !fw_issue) begin
      if (pending_q == '0) err_d = 1'b1;
      else                 pending_d = pending_q - 1'b1;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (br_valid && !resolve) state_d = WAIT;
      WAIT: if (!br_valid || resolve) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs. Gated by rst so nothing is acked during reset.
  always_comb begin
    stall  = 1'b0;
    br_ack = 1'b0;
    case (state_q)
      IDLE: begin
        stall  = br_valid && !resolve;
        br_ack = resolve;
      end
      WAIT: begin
        stall  = br_valid && !resolve;
        br_ack = resolve;
      end
      default: ;
    endcase
    if (rst) begin
      stall  = 1'b0;
      br_ack = 1'b0;
    end
  end

  // Redirect datapath; redirect_pc only moves on a taken branch.
  always_comb begin
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    taken_d          = taken_q;
    if (br_ack) begin
      taken_d          = cond_true;
      redirect_valid_d = cond_true;
      if (cond_true) redirect_pc_d = target;
    end
  end

  // FSM + datapath state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      pending_q        <= '0;
      err_q            <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      taken_q          <= 1'b0;
    end else begin
      state_q          <= state_d;
      pending_q        <= pending_d;
      err_q            <= err_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      taken_q          <= taken_d;
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign taken          = taken_q;
  assign err            = err_q;

`ifdef BRANCH_STATS_EN
  logic [15:0] stat_branches_q, stat_branches_d;
  logic [15:0] stat_taken_q, stat_taken_d;

  always_comb begin
    stat_branches_d = stat_branches_q;
    stat_taken_d    = stat_taken_q;
    if (br_ack && stat_branches_q != 16'hFFFF) stat_branches_d = stat_branches_q + 16'd1;
    if (br_ack && cond_true && stat_taken_q != 16'hFFFF) stat_taken_d = stat_taken_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches_q <= '0;
      stat_taken_q    <= '0;
    end else begin
      stat_branches_q <= stat_branches_d;
      stat_taken_q    <= stat_taken_d;
    end
  end

  assign stat_branches = stat_branches_q;
  assign stat_taken    = stat_taken_q;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Directed testbench for branch_resolver. Inputs are driven 1 ns after the
// rising edge; combinational outputs are sampled 1 ns later, registered
// outputs right after the edge that loads them.
module tb_branch_resolver;

  logic        clk;
  logic        rst;
  logic [2:0]  flags;
  logic        fw_issue;
  logic        fw_commit;
  logic        br_valid;
  logic [2:0]  br_ccc;
  logic        br_reg;
  logic [15:0] br_pc_plus2;
  logic [8:0]  br_imm;
  logic [15:0] br_rs_data;
  logic        stall;
  logic        br_ack;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        taken;
  logic        err;
`ifdef BRANCH_STATS_EN
  logic [15:0] stat_branches;
  logic [15:0] stat_taken;
`endif

  int checks = 0;
  int errors = 0;

  branch_resolver #(.MAX_INFLIGHT(3), .PC_W(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .flags          (flags),
    .fw_issue       (fw_issue),
    .fw_commit      (fw_commit),
    .br_valid       (br_valid),
    .br_ccc         (br_ccc),
    .br_reg         (br_reg),
    .br_pc_plus2    (br_pc_plus2),
    .br_imm         (br_imm),
    .br_rs_data     (br_rs_data),
    .stall          (stall),
    .br_ack         (br_ack),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .taken          (taken),
    .err            (err)
`ifdef BRANCH_STATS_EN
    ,
    .stat_branches  (stat_branches),
    .stat_taken     (stat_taken)
`endif
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flags       = 3'b000;
    fw_issue    = 1'b0;
    fw_commit   = 1'b0;
    br_valid    = 1'b0;
    br_ccc      = 3'b000;
    br_reg      = 1'b0;
    br_pc_plus2 = 16'h0000;
    br_imm      = 9'h000;
    br_rs_data  = 16'h0000;
  endtask

  task automatic drive_branch(input logic [2:0] ccc, input logic reg_sel,
                              input logic [15:0] pc2, input logic [8:0] imm,
                              input logic [15:0] rs);
    br_valid    = 1'b1;
    br_ccc      = ccc;
    br_reg      = reg_sel;
    br_pc_plus2 = pc2;
    br_imm      = imm;
    br_rs_data  = rs;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_branch(3'b111, 1'b0, 16'h1234, 9'h001, 16'h0000);
    repeat (2) tick();
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
    checks++; if (br_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", br_ack); end
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL reset_rv: got %b want 0", redirect_valid); end
    checks++; if (redirect_pc !== 16'h0000) begin errors++; $display("FAIL reset_rpc: got %h want 0000", redirect_pc); end
    checks++; if (taken !== 1'b0) begin errors++; $display("FAIL reset_taken: got %b want 0", taken); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
`ifdef BRANCH_STATS_EN
    checks++; if (stat_branches !== 16'h0) begin errors++; $display("FAIL reset_stat_br: got %h want 0000", stat_branches); end
`endif
    tick();
    rst = 1'b0;
    br_valid = 1'b0;
  endtask

  task automatic test_basic_taken();
    flags = 3'b100;
    drive_branch(3'b001, 1'b0, 16'h0010, 9'h003, 16'h0000);
    #1;
    checks++; if (br_ack !== 1'b1) begin errors++; $display("FAIL basic_ack: got %b want 1", br_ack); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL basic_stall: got %b want 0", stall); end
    tick();
    br_valid = 1'b0;
    checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL basic_rv: got %b want 1", redirect_valid); end
    checks++; if (redirect_pc !== 16'h0016) begin errors++; $display("FAIL basic_rpc: got %h want 0016", redirect_pc); end
    checks++; if (taken !== 1'b1) begin errors++; $display("FAIL basic_taken: got %b want 1", taken); end
    tick();
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL basic_rv_pulse: got %b want 0", redirect_valid); end
    checks++; if (taken !== 1'b1) begin errors++; $display("FAIL basic_taken_hold: got %b want 1", taken); end
`ifdef BRANCH_STATS_EN
    checks++; if (stat_branches !== 16'd1) begin errors++; $display("FAIL basic_stat_br: got %h want 0001", stat_branches); end
    checks++; if (stat_taken !== 16'd1) begin errors++; $display("FAIL basic_stat_tk: got %h want 0001", stat_taken); end
`endif
  endtask

  task automatic test_flag_stall();
    fw_issue = 1'b1;
    tick();
    fw_issue = 1'b0;
    flags = 3'b100;
    drive_branch(3'b000, 1'b0, 16'h0100, 9'h1F0, 16'h0000);
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL fstall_first: got %b want 1", stall); end
    checks++; if (br_ack !== 1'b0) begin errors++; $display("FAIL fstall_noack: got %b want 0", br_ack); end
    tick();
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL fstall_wait: got %b want 1", stall); end
    fw_commit = 1'b1;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL fstall_commit_cycle: got %b want 1", stall); end
    tick();
    fw_commit = 1'b0;
    flags = 3'b000;
    #1;
    checks++; if (br_ack !== 1'b1) begin errors++; $display("FAIL fstall_ack: got %b want 1", br_ack); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL fstall_release: got %b want 0", stall); end
    tick();
    br_valid = 1'b0;
    checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL fstall_rv: got %b want 1", redirect_valid); end
    checks++; if (redirect_pc !== 16'h00E0) begin errors++; $display("FAIL fstall_rpc: got %h want 00e0", redirect_pc); end
  endtask

  task automatic test_uncond_pending();
    fw_issue = 1'b1;
    repeat (2) tick();
    fw_issue = 1'b0;
    flags = 3'b000;
    drive_branch(3'b111, 1'b0, 16'h2000, 9'h010, 16'h0000);
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL uncond_stall: got %b want 0", stall); end
    checks++; if (br_ack !== 1'b1) begin errors++; $display("FAIL uncond_ack: got %b want 1", br_ack); end
    tick();
    br_valid = 1'b0;
    checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL uncond_rv: got %b want 1", redirect_valid); end
    checks++; if (redirect_pc !== 16'h2020) begin errors++; $display("FAIL uncond_rpc: got %h want 2020", redirect_pc); end
    fw_commit = 1'b1;
    repeat (2) tick();
    fw_commit = 1'b0;
  endtask

  task automatic test_back_to_back();
    flags = 3'b001;
    drive_branch(3'b010, 1'b0, 16'h0040, 9'h005, 16'h0000);
    #1;
    checks++; if (br_ack !== 1'b1) begin errors++; $display("FAIL b2b_ack0: got %b want 1", br_ack); end
    tick();
    drive_branch(3'b111, 1'b0, 16'h0000, 9'h1FF, 16'h0000);
    checks++; if (taken !== 1'b0) begin errors++; $display("FAIL b2b_nt_taken: got %b want 0", taken); end
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL b2b_nt_rv: got %b want 0", redirect_valid); end
    checks++; if (redirect_pc !== 16'h2020) begin errors++; $display("FAIL b2b_nt_rpc_hold: got %h want 2020", redirect_pc); end
    #1;
    checks++; if (br_ack !== 1'b1) begin errors++; $display("FAIL b2b_ack1: got %b want 1", br_ack); end
    tick();
    drive_branch(3'b111, 1'b1, 16'h0000, 9'h000, 16'hABCD);
    checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL b2b_wrap_rv: got %b want 1", redirect_valid); end
    checks++; if (redirect_pc !== 16'hFFFE) begin errors++; $display("FAIL b2b_wrap_rpc: got %h want fffe", redirect_pc); end
    #1;
    checks++; if (br_ack !== 1'b1) begin errors++; $display("FAIL b2b_ack2: got %b want 1", br_ack); end
    tick();
    br_valid = 1'b0;
    br_reg = 1'b0;
    checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL b2b_reg_rv: got %b want 1", redirect_valid); end
    checks++; if (redirect_pc !== 16'hABCD) begin errors++; $display("FAIL b2b_reg_rpc: got %h want abcd", redirect_pc); end
    tick();
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL b2b_rv_end: got %b want 0", redirect_valid); end
  endtask

  task automatic test_issue_commit_same();
    fw_issue = 1'b1;
    tick();
    fw_issue = 1'b0;
    flags = 3'b100;
    drive_branch(3'b001, 1'b0, 16'h0300, 9'h004, 16'h0000);
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL ic_stall0: got %b want 1", stall); end
    tick();
    fw_issue = 1'b1;
    fw_commit = 1'b1;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL ic_stall_both: got %b want 1", stall); end
    tick();
    fw_issue = 1'b0;
    fw_commit = 1'b0;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL ic_pending_kept: got %b want 1", stall); end
    tick();
    fw_commit = 1'b1;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL ic_stall_commit: got %b want 1", stall); end
    tick();
    fw_commit = 1'b0;
    #1;
    checks++; if (br_ack !== 1'b1) begin errors++; $display("FAIL ic_ack: got %b want 1", br_ack); end
    tick();
    br_valid = 1'b0;
    checks++; if (redirect_pc !== 16'h0308) begin errors++; $display("FAIL ic_rpc: got %h want 0308", redirect_pc); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL ic_err_clear: got %b want 0", err); end
    fw_commit = 1'b1;
    tick();
    fw_commit = 1'b0;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL underflow_err: got %b want 1", err); end
    tick();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", err); end
  endtask

  task automatic test_reset_in_wait();
    fw_issue = 1'b1;
    tick();
    fw_issue = 1'b0;
    flags = 3'b000;
    drive_branch(3'b000, 1'b0, 16'h0500, 9'h000, 16'h0000);
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rw_stall: got %b want 1", stall); end
    tick();
    rst = 1'b1;
    #1;
    checks++; if (br_ack !== 1'b0) begin errors++; $display("FAIL rw_ack_in_rst: got %b want 0", br_ack); end
    tick();
    rst = 1'b0;
    br_valid = 1'b0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rw_stall_after: got %b want 0", stall); end
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL rw_rv: got %b want 0", redirect_valid); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rw_err_cleared: got %b want 0", err); end
`ifdef BRANCH_STATS_EN
    checks++; if (stat_branches !== 16'h0) begin errors++; $display("FAIL rw_stat_br: got %h want 0000", stat_branches); end
    checks++; if (stat_taken !== 16'h0) begin errors++; $display("FAIL rw_stat_tk: got %h want 0000", stat_taken); end
`endif
    tick();
    drive_branch(3'b000, 1'b0, 16'h0500, 9'h000, 16'h0000);
    #1;
    checks++; if (br_ack !== 1'b1) begin errors++; $display("FAIL rw_pending_zero: got %b want 1", br_ack); end
    tick();
    br_valid = 1'b0;
    checks++; if (redirect_pc !== 16'h0500) begin errors++; $display("FAIL rw_rpc: got %h want 0500", redirect_pc); end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_basic_taken();
    test_flag_stall();
    test_uncond_pending();
    test_back_to_back();
    test_issue_commit_same();
    test_reset_in_wait();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
